// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready depends only on the stored state, so backpressure never ripples combinationally upstream.
module pipe_skid_reg #(
  parameter int                 DATA_W  = 8,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0,
  parameter int                 CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              clr_cnt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic [CNT_W-1:0]  stall_q;
  logic              in_fire, out_fire;

  assign in_ready  = (state != TWO) & ~reset;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = {state == TWO, state == ONE};
  assign stall_cnt = stall_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      // A simultaneous in_fire is dropped; the upstream stage is being flushed as well.
      state_nxt = EMPTY;
      main_nxt  = NOP_VAL;
      skid_nxt  = NOP_VAL;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            state_nxt = TWO;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
            main_nxt  = NOP_VAL;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
            skid_nxt  = NOP_VAL;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = NOP_VAL;
          skid_nxt  = NOP_VAL;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= NOP_VAL;
      skid_q <= NOP_VAL;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  // Stall counter survives flush; only reset or clr_cnt clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (clr_cnt) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && stall_q != CNT_MAX) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based model of the stage (two instances: 16- and 3-bit counters).
module tb_pipe_skid_reg;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       clr_cnt;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic        in_ready_a, out_valid_a;
  logic [7:0]  out_data_a;
  logic [1:0]  occupancy_a;
  logic [15:0] stall_cnt_a;

  logic        in_ready_b, out_valid_b;
  logic [7:0]  out_data_b;
  logic [1:0]  occupancy_b;
  logic [2:0]  stall_cnt_b;

  int tests;
  int fails;

  // Behavioural model: the stage is a FIFO of at most two entries.
  logic [7:0] q[$];
  int         m_stall16;
  int         m_stall3;

  pipe_skid_reg #(.DATA_W(8), .NOP_VAL(8'h00), .CNT_W(16)) dut16 (
    .clk(clk), .reset(reset), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .occupancy(occupancy_a), .stall_cnt(stall_cnt_a)
  );

  pipe_skid_reg #(.DATA_W(8), .NOP_VAL(8'h00), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .occupancy(occupancy_b), .stall_cnt(stall_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on each active edge, then compare both DUTs just after it.
  always @(posedge clk) begin
    int  sz;
    bit  inf;
    bit  outf;
    logic [7:0] exp_data;
    if (reset) begin
      q.delete();
      m_stall16 = 0;
      m_stall3  = 0;
    end else begin
      sz   = q.size();
      inf  = in_valid && (sz < 2);
      outf = (sz > 0) && out_ready;
      if (clr_cnt) begin
        m_stall16 = 0;
        m_stall3  = 0;
      end else if (sz > 0 && !out_ready) begin
        if (m_stall16 < 65535) m_stall16++;
        if (m_stall3 < 7) m_stall3++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(in_data);
      end
    end
    #1;
    exp_data = (q.size() > 0) ? q[0] : 8'h00;
    check("out_valid16", 32'(out_valid_a), 32'(q.size() > 0));
    check("out_data16",  32'(out_data_a),  32'(exp_data));
    check("occupancy16", 32'(occupancy_a), 32'(q.size()));
    check("in_ready16",  32'(in_ready_a),  32'(q.size() < 2 && !reset));
    check("stall_cnt16", 32'(stall_cnt_a), 32'(m_stall16));
    check("out_data3",   32'(out_data_b),  32'(exp_data));
    check("occupancy3",  32'(occupancy_b), 32'(q.size()));
    check("stall_cnt3",  32'(stall_cnt_b), 32'(m_stall3));
  end

  // Called at a negedge: apply inputs, let one active edge pass, return at the next negedge.
  task automatic tick(input logic iv, input logic [7:0] id, input logic ordy,
                      input logic fl = 1'b0, input logic clr = 1'b0);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    clr_cnt   = clr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    flush = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset landing in TWO with 0xA5 at the head.
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b1, 8'h5A, 1'b0);
    check("t1_pre_occ",  32'(occupancy_a), 32'd2);
    check("t1_pre_data", 32'(out_data_a),  32'hA5);
    check("t1_model_occ", 32'(q.size()),   32'd2);
    #2 reset = 1'b1;
    #1;
    check("t1_valid", 32'(out_valid_a), 32'd0);
    check("t1_data",  32'(out_data_a),  32'h00);
    check("t1_occ",   32'(occupancy_a), 32'd0);
    check("t1_ready", 32'(in_ready_a),  32'd0);
    check("t1_stall", 32'(stall_cnt_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Streaming with out_ready held high.
    tick(1'b1, 8'h11, 1'b1);
    check("t2_d0", 32'(out_data_a), 32'h11);
    check("t2_o0", 32'(occupancy_a), 32'd1);
    tick(1'b1, 8'h22, 1'b1);
    check("t2_d1", 32'(out_data_a), 32'h22);
    check("t2_r1", 32'(in_ready_a), 32'd1);
    tick(1'b1, 8'h33, 1'b1);
    check("t2_d2", 32'(out_data_a), 32'h33);
    tick(1'b0, 8'h00, 1'b1);
    check("t2_empty", 32'(out_valid_a), 32'd0);

    // Backpressure into the skid entry, then drain in order.
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b1, 8'h5A, 1'b0);
    check("t3_occ",   32'(occupancy_a), 32'd2);
    check("t3_ready", 32'(in_ready_a),  32'd0);
    tick(1'b0, 8'h00, 1'b0);
    check("t3_hold",  32'(out_data_a),  32'hA5);
    tick(1'b0, 8'h00, 1'b1);
    check("t3_second", 32'(out_data_a), 32'h5A);
    check("t3_model_head", 32'(q[0]),   32'h5A);
    tick(1'b0, 8'h00, 1'b1);
    check("t3_drained", 32'(occupancy_a), 32'd0);

    // Flush in TWO, then flush in ONE with a live in_fire that must be discarded.
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b1, 8'h5A, 1'b0);
    tick(1'b1, 8'h77, 1'b0, 1'b1);
    check("t4_valid", 32'(out_valid_a), 32'd0);
    check("t4_data",  32'(out_data_a),  32'h00);
    check("t4_occ",   32'(occupancy_a), 32'd0);
    tick(1'b1, 8'h10, 1'b0);
    tick(1'b1, 8'h77, 1'b0, 1'b1);
    check("t4b_occ",  32'(occupancy_a), 32'd0);
    tick(1'b0, 8'h00, 1'b1);
    check("t4b_no77", 32'(out_valid_a), 32'd0);

    // Stall counter saturation on the 3-bit instance, clear, and survival across flush.
    do_reset();
    tick(1'b1, 8'h99, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 8'h00, 1'b0);
    check("t5_sat3",  32'(stall_cnt_b), 32'd7);
    check("t5_cnt16", 32'(stall_cnt_a), 32'd10);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t5_clr3",  32'(stall_cnt_b), 32'd0);
    check("t5_clr16", 32'(stall_cnt_a), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check("t5_flush_keeps", 32'(stall_cnt_a), 32'd1);

    // Simultaneous in_fire and out_fire while ONE.
    tick(1'b1, 8'h40, 1'b0);
    tick(1'b1, 8'h41, 1'b1);
    check("t6_data", 32'(out_data_a),  32'h41);
    check("t6_occ",  32'(occupancy_a), 32'd1);

    // Random traffic checked cycle by cycle by the model process.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 255) == 0);
      tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    end
    reset = 1'b0;
    tick(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
